wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
N-master round-robin Wishbone arbiter that shares one line-width external memory bus among cache ports, DMA and debug requesters.
- Generalises the fixed 2-port arbitration in the memory controller to NUM_MASTERS ports.
- Adds fair rotation, bus-cycle locking through cyc, and an optional stalled-slave watchdog.
- Sits between the requesting masters and the single external Wishbone slave.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
DATA_WIDTH, 128, bus data width in bits
ADDR_WIDTH, 32, bus address width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses; master m at slice m
wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data
wbm_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
wbm_we_i  in  NUM_MASTERS  write enables
wbm_stb_i  in  NUM_MASTERS  strobes
wbm_cyc_i  in  NUM_MASTERS  bus-cycle requests
wbm_dat_o  out  DATA_WIDTH  slave read data, broadcast to all masters
wbm_ack_o  out  NUM_MASTERS  ack, routed to the owner only
wbm_err_o  out  NUM_MASTERS  err, routed to the owner only
wbm_rty_o  out  NUM_MASTERS  rty, routed to the owner only
wbs_adr_o  out  ADDR_WIDTH  address to slave
wbs_dat_o  out  DATA_WIDTH  write data to slave
wbs_sel_o  out  SEL_WIDTH  byte selects to slave
wbs_we_o  out  1  write enable to slave
wbs_stb_o  out  1  strobe to slave
wbs_cyc_o  out  1  cycle to slave
wbs_dat_i  in  DATA_WIDTH  slave read data
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave err
wbs_rty_i  in  1  slave rty
grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle
timeout_o  out  1  watchdog pulse; tied 0 without the optional feature

Behaviour:
- Registered state: grant_valid, owner index, last_owner index.
- Reset values: grant_valid=0; last_owner=NUM_MASTERS-1, so master 0 has first priority; grant_o=0.
- Slave outputs at reset: wbs_cyc_o=0, wbs_stb_o=0, wbs_we_o=0.
- Master outputs at reset: all wbm_ack_o/err_o/rty_o=0.
- Reset asserted mid-transfer drops the grant on the next edge, with no ack forwarded after that edge.
- States: IDLE (grant_valid=0) and OWNED (grant_valid=1).
- IDLE: if any wbm_cyc_i is high, select the first requester scanning last_owner+1, last_owner+2, ..., wrapping modulo NUM_MASTERS.
  - Next cycle: OWNED, owner=selected, last_owner=selected.
  - Grant latency is exactly 1 cycle from cyc rising in IDLE.
- OWNED: the owner keeps the bus for as long as wbm_cyc_i[owner]=1, across any number of stb/ack beats (locked cycle).
- OWNED with wbm_cyc_i[owner]=0:
  - Slave cyc/stb drop combinationally in that same cycle.
  - Next state is IDLE.
  - No re-arbitration in the release cycle: a minimum one idle cycle between owners.
- Muxing in OWNED:
  - wbs_adr/dat/sel/we come from the owner.
  - wbs_stb_o = wbm_stb_i[owner] & wbm_cyc_i[owner].
  - wbs_cyc_o = wbm_cyc_i[owner].
- Muxing in IDLE: wbs_cyc_o=wbs_stb_o=wbs_we_o=0; adr/dat/sel are don't-care.
- Response routing: wbm_ack_o[m] = wbs_ack_i & grant_valid & (owner==m), and the same for err and rty. Non-owners always see 0.
- Simultaneous requests: the lowest rotated index wins, with strict rotation.
  - Example with NUM_MASTERS=4, last_owner=1 and masters 0 and 3 requesting: master 3 wins.
- Single requester: it is re-granted after each release plus one idle cycle; no starvation exists because rotation passes every requester.
- A master dropping cyc before it is granted is simply not selected; nothing is latched.
- Index width is $clog2(NUM_MASTERS). Wrap uses an explicit compare to NUM_MASTERS-1 and does not rely on power-of-two overflow.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments while OWNED and wbs_stb_o=1 and ack/err/rty are all 0.
  - The counter clears on any response or on release.
  - When the counter reaches TIMEOUT_CYCLES: wbm_err_o[owner]=1 for exactly one cycle, timeout_o=1 for the same cycle, wbs_stb_o is forced 0 for that cycle, and the counter clears.
  - The grant is retained until the owner drops cyc.
- Undefined: no counter, timeout_o tied 0, a hung slave stalls the bus indefinitely.

Test Plan:
- Reset release, master 0 raises cyc/stb, adr=0x00001000, read -> grant_o=0001 after 1 cycle; wbs_adr_o=0x00001000; slave ack forwarded only to wbm_ack_o[0].
- All 4 masters hold cyc continuously, each dropping cyc after one acked beat -> grant order 0,1,2,3,0 with one idle cycle between owners.
- Master 2 holds cyc for 3 stb/ack beats while master 1 requests -> master 2 keeps ownership for all 3 beats; master 1 is granted 2 cycles after master 2 drops cyc; wbm_ack_o[1] stays 0 throughout.
- Write from master 3, we=1, sel=0x000F, dat low word 0xDEADBEEF -> wbs_we_o=1, wbs_sel_o=0x000F and wbs_dat_o low word 0xDEADBEEF while granted.
- rst asserted during master 1's owned cycle with ack pending -> next cycle grant_o=0, wbs_cyc_o=0; a later ack_i is not routed; the next arbitration starts at master 0.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> after 16 stalled cycles there is a one-cycle pulse on wbm_err_o[owner] and timeout_o, with wbs_stb_o=0 in that cycle.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one slave; ownership is locked by cyc.
// Optional stalled-slave watchdog is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]            wbm_we_i,
  input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]             wbm_dat_o,
  output logic [NUM_MASTERS-1:0]            wbm_ack_o,
  output logic [NUM_MASTERS-1:0]            wbm_err_o,
  output logic [NUM_MASTERS-1:0]            wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]             wbs_adr_o,
  output logic [DATA_WIDTH-1:0]             wbs_dat_o,
  output logic [SEL_WIDTH-1:0]              wbs_sel_o,
  output logic                              wbs_we_o,
  output logic                              wbs_stb_o,
  output logic                              wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]             wbs_dat_i,
  input  logic                              wbs_ack_i,
  input  logic                              wbs_err_i,
  input  logic                              wbs_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;

  logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign adr_arr[gi] = wbm_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[gi] = wbm_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[gi] = wbm_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
  end

  // Scan last_owner+1, last_owner+2, ... with an explicit wrap so non-power-of-two counts work.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = last_owner_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      if (!pick_found && wbm_cyc_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic owner_cyc;
  assign owner_cyc = wbm_cyc_i[owner_q];

  // The release cycle never re-arbitrates, which guarantees an idle cycle between owners.
  always_comb begin
    grant_valid_d = grant_valid_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    if (!grant_valid_q) begin
      if (pick_found) begin
        grant_valid_d = 1'b1;
        owner_d       = pick_idx;
        last_owner_d  = pick_idx;
      end
    end else if (!owner_cyc) begin
      grant_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_valid_q <= 1'b0;
      owner_q       <= '0;
      last_owner_q  <= LAST_IDX;
    end else begin
      grant_valid_q <= grant_valid_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
    end
  end

  logic stb_raw;
  logic to_hit;
  logic any_resp;

  assign any_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wbs_cyc_o = grant_valid_q & owner_cyc;
  assign stb_raw   = wbs_cyc_o & wbm_stb_i[owner_q];
  assign wbs_stb_o = stb_raw & ~to_hit;
  assign wbs_we_o  = grant_valid_q & wbm_we_i[owner_q];
  assign wbs_adr_o = adr_arr[owner_q];
  assign wbs_dat_o = dat_arr[owner_q];
  assign wbs_sel_o = sel_arr[owner_q];
  assign wbm_dat_o = wbs_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = stb_raw & ~any_resp & (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!wbs_cyc_o || any_resp || to_hit) begin
      to_cnt_d = '0;
    end else if (stb_raw) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_o = to_hit;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
    logic is_owner;
    assign is_owner      = grant_valid_q & (owner_q == IDX_W'(gi));
    assign grant_o[gi]   = is_owner;
    assign wbm_ack_o[gi] = is_owner & wbs_ack_i;
    assign wbm_err_o[gi] = is_owner & (wbs_err_i | to_hit);
    assign wbm_rty_o[gi] = is_owner & wbs_rty_i;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomised and directed bench for wb_rr_arbiter against a cycle-level round-robin model.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int SW = DW/8;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic [SW-1:0] m_sel [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign wbm_adr_i[gi*AW +: AW] = m_adr[gi];
    assign wbm_dat_i[gi*DW +: DW] = m_dat[gi];
    assign wbm_sel_i[gi*SW +: SW] = m_sel[gi];
  end

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_stb_i(wbm_stb_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int own      = -1;     // model owner, -1 means idle
  int last     = N - 1;  // model last owner
  int beat_done = -1;
  int beats [N];
  int grant_log [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] eg;
    logic e_cyc, e_stb, e_we;
    @(negedge clk);
    eg = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      e_cyc   = wbm_cyc_i[own];
      e_stb   = e_cyc & wbm_stb_i[own];
      e_we    = wbm_we_i[own];
    end
    chk("grant", grant_o, eg);
    chk("wbs_cyc", wbs_cyc_o, e_cyc);
    chk("wbs_stb", wbs_stb_o, e_stb);
    chk("wbs_we", wbs_we_o, e_we);
    chk("ack", wbm_ack_o, wbs_ack_i ? eg : '0);
    chk("err", wbm_err_o, wbs_err_i ? eg : '0);
    chk("rty", wbm_rty_o, wbs_rty_i ? eg : '0);
    chk("timeout", timeout_o, 1'b0);
    chk("rdata", wbm_dat_o, wbs_dat_i);
    if (e_cyc) begin
      chk("wbs_adr", wbs_adr_o, m_adr[own]);
      chk("wbs_dat", wbs_dat_o, m_dat[own]);
      chk("wbs_sel", wbs_sel_o, m_sel[own]);
    end
  endtask

  task automatic advance();
    int p;
    @(posedge clk);
    beat_done = -1;
    if (own >= 0 && wbm_cyc_i[own] && wbm_stb_i[own] && (wbs_ack_i | wbs_err_i | wbs_rty_i))
      beat_done = own;
    if (rst) begin
      own = -1;
      last = N - 1;
    end else if (own < 0) begin
      p = rr_pick(last, wbm_cyc_i);
      if (p >= 0) begin
        own = p;
        last = p;
        grant_log.push_back(p);
        $display("grant master=%0d t=%0t", p, $time);
      end
    end else if (!wbm_cyc_i[own]) begin
      own = -1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      check_cycle();
      advance();
    end
  endtask

  task automatic new_req(input int m);
    m_adr[m] = $urandom;
    m_dat[m] = {$urandom, $urandom, $urandom, $urandom};
    m_sel[m] = SW'($urandom);
    wbm_we_i[m] = 1'($urandom);
  endtask

  task automatic rand_drive();
    logic es;
    for (int m = 0; m < N; m++) begin
      if (m == beat_done) begin
        beats[m]--;
        if (beats[m] <= 0) begin
          wbm_cyc_i[m] = 1'b0;
          wbm_stb_i[m] = 1'b0;
        end else begin
          new_req(m);
        end
      end else if (!wbm_cyc_i[m]) begin
        if ($urandom_range(3) == 0) begin
          new_req(m);
          beats[m] = int'($urandom_range(3, 1));
          wbm_cyc_i[m] = 1'b1;
          wbm_stb_i[m] = 1'b1;
        end
      end else if (own != m && $urandom_range(15) == 0) begin
        wbm_cyc_i[m] = 1'b0;
        wbm_stb_i[m] = 1'b0;
      end
      if (wbm_cyc_i[m] && own == m) wbm_stb_i[m] = ($urandom_range(3) != 0);
    end
    es = (own >= 0) && wbm_cyc_i[own] && wbm_stb_i[own];
    wbs_ack_i = es && ($urandom_range(1) == 0);
    wbs_err_i = es && !wbs_ack_i && ($urandom_range(7) == 0);
    wbs_rty_i = es && !wbs_ack_i && !wbs_err_i && ($urandom_range(7) == 0);
    if (own < 0) wbs_ack_i = ($urandom_range(7) == 0);
    wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
    rst = ($urandom_range(499) == 0);
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    wbs_dat_i = '0;
    clear_inputs();
    for (int m = 0; m < N; m++) begin
      m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; beats[m] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_cycle();
    chk("rst_grant", grant_o, '0);
    chk("rst_cyc", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b000);
    advance();
    rst = 1'b0;

    // Single read from master 0, one-cycle grant latency.
    wbm_cyc_i[0] = 1'b1; wbm_stb_i[0] = 1'b1; m_adr[0] = 32'h0000_1000;
    check_cycle(); chk("t1_lat", grant_o, '0); advance();
    wbs_ack_i = 1'b1;
    check_cycle();
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_adr", wbs_adr_o, 32'h0000_1000);
    chk("t1_ack", wbm_ack_o, 4'b0001);
    advance();
    idle(2);

    // Everyone requests; each owner releases after one beat.
    rst = 1'b1; check_cycle(); advance(); rst = 1'b0;
    grant_log.delete();
    wbm_cyc_i = '1; wbm_stb_i = '1; wbs_ack_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      check_cycle();
      advance();
      for (int m = 0; m < N; m++) begin
        wbm_cyc_i[m] = (m != beat_done);
        wbm_stb_i[m] = (m != beat_done);
      end
    end
    chk("t2_count", grant_log.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++)
      chk("t2_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
    idle(2);

    // Locked cycle: master 2 holds three beats while master 1 waits.
    wbm_cyc_i[2] = 1'b1; wbm_stb_i[2] = 1'b1; m_adr[2] = 32'h0000_2000;
    check_cycle(); advance();
    wbm_cyc_i[1] = 1'b1; wbm_stb_i[1] = 1'b1; wbs_ack_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      check_cycle();
      chk("t3_own", grant_o, 4'b0100);
      chk("t3_ack1", wbm_ack_o[1], 1'b0);
      chk("t3_ack2", wbm_ack_o[2], 1'b1);
      advance();
    end
    wbm_cyc_i[2] = 1'b0; wbm_stb_i[2] = 1'b0; wbs_ack_i = 1'b0;
    check_cycle(); chk("t3_rel", wbs_cyc_o, 1'b0); advance();
    check_cycle(); chk("t3_gap", grant_o, '0); advance();
    check_cycle(); chk("t3_m1", grant_o, 4'b0010); chk("t3_ack1b", wbm_ack_o[1], 1'b0); advance();

    // Write from master 3.
    wbm_cyc_i[1] = 1'b0; wbm_stb_i[1] = 1'b0;
    wbm_cyc_i[3] = 1'b1; wbm_stb_i[3] = 1'b1; wbm_we_i[3] = 1'b1;
    m_sel[3] = 16'h000F; m_dat[3] = {96'h0, 32'hDEAD_BEEF}; m_adr[3] = 32'h0000_3000;
    check_cycle(); advance();
    check_cycle(); advance();
    check_cycle();
    chk("t4_grant", grant_o, 4'b1000);
    chk("t4_we", wbs_we_o, 1'b1);
    chk("t4_sel", wbs_sel_o, 16'h000F);
    chk("t4_dat", wbs_dat_o[31:0], 32'hDEAD_BEEF);
    advance();
    idle(3);

    // Reset while master 1 owns the bus with an ack pending.
    wbm_cyc_i[1] = 1'b1; wbm_stb_i[1] = 1'b1;
    check_cycle(); advance();
    rst = 1'b1;
    check_cycle(); chk("t5_own", grant_o, 4'b0010); advance();
    rst = 1'b0; wbs_ack_i = 1'b1;
    wbm_cyc_i[0] = 1'b1; wbm_stb_i[0] = 1'b1; wbm_cyc_i[3] = 1'b1; wbm_stb_i[3] = 1'b1;
    check_cycle();
    chk("t5_grant", grant_o, '0);
    chk("t5_cyc", wbs_cyc_o, 1'b0);
    chk("t5_ack", wbm_ack_o, '0);
    advance();
    wbs_ack_i = 1'b0;
    check_cycle(); chk("t5_first", grant_o, 4'b0001); advance();
    idle(3);

    // last_owner=1 with masters 0 and 3 requesting: 3 wins.
    wbm_cyc_i[1] = 1'b1; wbm_stb_i[1] = 1'b1;
    check_cycle(); advance();
    wbm_cyc_i = 4'b1001; wbm_stb_i = 4'b1001;
    check_cycle(); advance();
    check_cycle(); advance();
    check_cycle(); chk("t6_win3", grant_o, 4'b1000); advance();
    idle(3);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      check_cycle();
      advance();
      rand_drive();
    end
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
